sm4_stream_ctrl: RTL and testbench

SM4_STREAM_CTRL -- requirements
Module: sm4_stream_ctrl

---
 rtl/sm4_pkg.sv | 30 +++
 rtl/sm4_stream_ctrl.sv | 118 +++++++++++
 tb/tb_sm4_stream_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sm4_pkg.sv
// Shared definitions for the SM4 stream controller.
//   state_t        - controller FSM encoding
//   CORE_LAT_DEF   - default cycles from end of core_load until core_y is sampled
//   WORDS_PER_BLK  - 32-bit words per 128-bit SM4 block
//   blk_word()     - selects word idx (0 = most significant) of a 128-bit block
package sm4_pkg;

    typedef enum logic [2:0] {
        COLLECT = 3'd0,
        LOAD    = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        DRAIN   = 3'd4
    } state_t;

    localparam int CORE_LAT_DEF  = 66;
    localparam int WORDS_PER_BLK = 4;

    function automatic logic [31:0] blk_word(input logic [127:0] blk, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            2'd0:    w = blk[127:96];
            2'd1:    w = blk[95:64];
            2'd2:    w = blk[63:32];
            default: w = blk[31:0];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sm4_stream_ctrl.sv
// Streams 32-bit text words into a 128-bit SM4 block, launches an external
// SM4 core, waits a fixed latency, captures the result and streams it out.
// Ports:
//   clk, reset (async, active low)
//   in_valid/in_ready/in_data  - input word stream, MS word first
//   mode_in, key_in            - sampled with the 4th input word
//   core_load/core_mode/core_mk/core_x - drive the SM4 core
//   core_y                     - core result, trusted after CORE_LAT cycles
//   out_valid/out_ready/out_data/out_last - result word stream, MS word first
module sm4_stream_ctrl
    import sm4_pkg::*;
#(
    parameter int CORE_LAT = CORE_LAT_DEF,
    parameter int CNT_W    = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         mode_in,
    input  logic [127:0] key_in,
    output logic         core_load,
    output logic         core_mode,
    output logic [127:0] core_mk,
    output logic [127:0] core_x,
    input  logic [127:0] core_y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         out_last
);

    state_t           state_q, state_d;
    logic [1:0]       word_cnt;
    logic [1:0]       word_nxt;
    logic [CNT_W-1:0] lat_cnt;
    logic [127:0]     asm_q;     // partial block being assembled
    logic [127:0]     result_q;
    logic             in_acc, out_acc, lat_done;

    assign in_acc   = in_valid & in_ready;
    assign out_acc  = out_valid & out_ready;
    assign word_nxt = word_cnt + 2'd1;
    assign lat_done = (lat_cnt == CNT_W'(CORE_LAT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= COLLECT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (in_acc && word_cnt == 2'd3)  state_d = LOAD;
            LOAD:                                      state_d = WAIT;
            WAIT:    if (lat_done)                     state_d = CAPTURE;
            CAPTURE:                                   state_d = DRAIN;
            DRAIN:   if (out_acc && word_cnt == 2'd3) state_d = COLLECT;
            default:                                   state_d = COLLECT;
        endcase
    end

    // Handshake/strobe outputs are registered from the next state, which
    // keeps in_ready low during reset and raises it on the first clock after.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            word_cnt  <= '0;
            lat_cnt   <= '0;
            asm_q     <= '0;
            core_x    <= '0;
            core_mk   <= '0;
            core_mode <= 1'b0;
            result_q  <= '0;
            core_load <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            in_ready  <= (state_d == COLLECT);
            out_valid <= (state_d == DRAIN);
            core_load <= (state_d == LOAD);
            lat_cnt   <= (state_q == WAIT) ? lat_cnt + 1'b1 : '0;

            case (state_q)
                COLLECT: if (in_acc) begin
                    word_cnt <= word_nxt;
                    case (word_cnt)
                        2'd0: asm_q[127:96] <= in_data;
                        2'd1: asm_q[95:64]  <= in_data;
                        2'd2: asm_q[63:32]  <= in_data;
                        default: begin
                            asm_q[31:0] <= in_data;
                            // core inputs only change here, so they are
                            // held from LOAD until the next block's LOAD
                            core_x    <= {asm_q[127:32], in_data};
                            core_mk   <= key_in;
                            core_mode <= mode_in;
                        end
                    endcase
                end
                CAPTURE: begin
                    result_q <= core_y;
                    out_data <= core_y[127:96];
                    out_last <= 1'b0;
                end
                DRAIN: if (out_acc) begin
                    word_cnt <= word_nxt;
                    out_data <= blk_word(result_q, word_nxt);
                    out_last <= (word_nxt == 2'd3);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sm4_stream_ctrl.sv
// Directed bench for sm4_stream_ctrl with a behavioural stand-in for the
// SM4 core that only presents a valid result CORE_LAT cycles after load.
module tb_sm4_stream_ctrl;
    import sm4_pkg::*;

    localparam int LAT = 66;
    localparam logic [127:0] KEY = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] PT  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] CT  = 128'h681edf34d206965e86b3e94f536e4246;

    logic         clk = 0, reset = 0;
    logic         in_valid = 0, in_ready, mode_in = 0, out_ready = 0;
    logic [31:0]  in_data = 0, out_data;
    logic [127:0] key_in = 0, core_mk, core_x, core_y;
    logic         core_load, core_mode, out_valid, out_last;

    int tests = 0, fails = 0, cyc = 0, nloads = 0;
    int load_cyc[$];
    int core_cnt = LAT + 5;

    sm4_stream_ctrl #(.CORE_LAT(LAT), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .mode_in(mode_in), .key_in(key_in),
        .core_load(core_load), .core_mode(core_mode), .core_mk(core_mk),
        .core_x(core_x), .core_y(core_y), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (core_load === 1'b1) begin
            nloads <= nloads + 1;
            load_cyc.push_back(cyc);
            core_cnt <= 0;
        end else if (core_cnt < LAT + 5) begin
            core_cnt <= core_cnt + 1;
        end
    end

    // Core stand-in: known answer pairs only, garbage before the latency expires.
    always_comb begin
        core_y = 128'hbad0bad0bad0bad0bad0bad0bad0bad0;
        if (core_cnt >= LAT && core_mk == KEY) begin
            if (core_mode && core_x == PT)       core_y = CT;
            else if (!core_mode && core_x == CT) core_y = PT;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send_block(input logic [127:0] blk, input logic mode, input bit gaps);
        for (int i = 0; i < 4; i++) begin
            int n;
            if (gaps) begin in_valid = 0; step(); step(); end
            in_valid = 1; in_data = blk[127-32*i -: 32];
            key_in = (i == 3) ? KEY : ~KEY; mode_in = (i == 3) ? mode : ~mode;
            n = 0;
            while (in_ready !== 1'b1 && n < 200) begin step(); n++; end
            if (n >= 200) begin
                tests++; fails++;
                $display("FAIL send_timeout word %0d: in_ready=%b required 1", i, in_ready);
            end
            step();
        end
        in_valid = 0; key_in = 0; mode_in = 0;
    endtask

    task automatic recv_block(input logic [127:0] blk, input string name);
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            while (out_valid !== 1'b1 && n < LAT + 40) begin step(); n++; end
            tests++;
            if (out_data !== blk[127-32*i -: 32] || out_last !== (i == 3) || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL %s word %0d: got data=%h last=%b valid=%b, required data=%h last=%b",
                         name, i, out_data, out_last, out_valid, blk[127-32*i -: 32], i == 3);
            end
            step();
        end
        out_ready = 0;
    endtask

    task automatic test_reset();
        reset = 0; step();
        tests++;
        if (in_ready !== 0 || out_valid !== 0 || core_load !== 0 || core_x !== 0 ||
            out_data !== 0 || out_last !== 0 || core_mk !== 0 || core_mode !== 0) begin
            fails++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b core_load=%b core_x=%h out_data=%h, required all 0",
                     in_ready, out_valid, core_load, core_x, out_data);
        end
        reset = 1; step();
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_encrypt();
        int n0 = nloads;
        send_block(PT, 1'b1, 0);
        tests++;
        if (core_x !== PT || core_mk !== KEY || core_mode !== 1'b1) begin
            fails++; $display("FAIL enc_core_inputs: x=%h mk=%h mode=%b required x=%h mk=%h mode=1",
                              core_x, core_mk, core_mode, PT, KEY);
        end
        recv_block(CT, "encrypt");
        tests++;
        if (nloads - n0 !== 1) begin
            fails++; $display("FAIL enc_load_count: %0d loads required 1", nloads - n0);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL enc_return_ready: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_decrypt();
        send_block(CT, 1'b0, 0);
        recv_block(PT, "decrypt");
    endtask

    task automatic test_backpressure();
        int n = 0;
        send_block(PT, 1'b1, 0);
        while (out_valid !== 1'b1 && n < LAT + 40) begin step(); n++; end
        for (int i = 0; i < 10; i++) begin
            tests++;
            if (out_data !== 32'h681edf34 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_last !== 1'b0) begin
                fails++;
                $display("FAIL backpressure cycle %0d: data=%h in_ready=%b valid=%b last=%b required 681edf34/0/1/0",
                         i, out_data, in_ready, out_valid, out_last);
            end
            step();
        end
        recv_block(CT, "after_backpressure");
    endtask

    task automatic test_back_to_back();
        int n0 = nloads;
        int q0 = load_cyc.size();
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    int n = 0;
                    in_valid = 1; in_data = PT[127-32*(i%4) -: 32];
                    key_in = KEY; mode_in = 1;
                    while (in_ready !== 1'b1 && n < 300) begin step(); n++; end
                    step();
                end
                in_valid = 0;
            end
            begin
                recv_block(CT, "b2b_first");
                recv_block(CT, "b2b_second");
            end
        join
        tests++;
        if (nloads - n0 !== 2) begin
            fails++; $display("FAIL b2b_load_count: %0d loads required 2", nloads - n0);
        end else begin
            tests++;
            if (load_cyc[q0+1] - load_cyc[q0] < LAT + 7) begin
                fails++; $display("FAIL b2b_spacing: %0d cycles required >= %0d",
                                  load_cyc[q0+1] - load_cyc[q0], LAT + 7);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        int n0;
        send_block(PT, 1'b1, 0);
        repeat (20) step();
        #2 reset = 0; #1;
        tests++;
        if (out_valid !== 0 || in_ready !== 0 || core_x !== 0 || core_load !== 0) begin
            fails++; $display("FAIL async_reset: out_valid=%b in_ready=%b core_x=%h required 0/0/0",
                              out_valid, in_ready, core_x);
        end
        step(); reset = 1;
        n0 = nloads;
        for (int i = 0; i < LAT + 20; i++) begin
            step();
            if (out_valid !== 0) begin
                tests++; fails++; $display("FAIL reset_out_valid cycle %0d: %b required 0", i, out_valid);
                break;
            end
        end
        tests++;
        if (nloads !== n0) begin
            fails++; $display("FAIL reset_no_load: %0d loads required 0", nloads - n0);
        end
        send_block(PT, 1'b1, 0);
        recv_block(CT, "after_reset");
    endtask

    task automatic test_gaps();
        int n0 = nloads;
        for (int i = 0; i < 4; i++) begin
            in_valid = 0; in_data = 32'hffffffff; step(); step();
            tests++;
            if (nloads !== n0 || in_ready !== 1'b1) begin
                fails++; $display("FAIL gap_early_load word %0d: loads=%0d ready=%b required 0/1",
                                  i, nloads - n0, in_ready);
            end
            in_valid = 1; in_data = PT[127-32*i -: 32];
            key_in = KEY; mode_in = 1; step();
        end
        in_valid = 0; step(); step();
        tests++;
        if (nloads - n0 !== 1) begin
            fails++; $display("FAIL gap_load: %0d loads required 1", nloads - n0);
        end
        recv_block(CT, "gaps");
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_back_to_back();
        test_reset_in_wait();
        test_gaps();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
